// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and constants for the system-control block.
package pcileech_sysctl_pkg;

    // Per-button debounce / long-press FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StHeld,
        StLong,
        StDbRelease
    } btn_state_e;

    // Per-LED drive modes (led_mode[2i+1:2i]).
    localparam logic [1:0] LED_PASS  = 2'b00;
    localparam logic [1:0] LED_INV   = 2'b01;
    localparam logic [1:0] LED_BLINK = 2'b10;
    localparam logic [1:0] LED_PWRON = 2'b11;

    // Counter width able to hold the larger of the two cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pcileech_sysctl_btn.sv
// One button: 2-flop synchroniser, debounce and long-press detection.
module pcileech_sysctl_btn
    import pcileech_sysctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned LONGPRESS_CYCLES = 500000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic long_held,
    output logic long_hit
);

    localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES, LONGPRESS_CYCLES);
    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] LpLast = CntW'(LONGPRESS_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            pressed;
    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            long_q, long_d;
    logic            hit_q, hit_d;

    // Synchroniser loads "released" on reset so no spurious press follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            long_q  <= long_d;
            hit_q   <= hit_d;
        end
    end

    // Next state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = StDbPress;
                end
            end
            StDbPress: begin
                if (!pressed) begin
                    state_d = StIdle;
                end else if (cnt_q == DbLast) begin
                    cnt_d   = '0;
                    state_d = StHeld;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = StDbRelease;
                end else if (cnt_q == LpLast) begin
                    state_d = StLong;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLong: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = StDbRelease;
                end
            end
            StDbRelease: begin
                // long_q remembers whether the release started from StLong.
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = long_q ? StLong : StHeld;
                end else if (cnt_q == DbLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output updates on the transitions that change them.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        long_d  = long_q;
        hit_d   = 1'b0;
        unique case (state_q)
            StDbPress: begin
                if (pressed && cnt_q == DbLast) begin
                    level_d = 1'b1;
                    press_d = 1'b1;
                end
            end
            StHeld: begin
                if (pressed && cnt_q == LpLast) begin
                    long_d = 1'b1;
                    hit_d  = 1'b1;
                end
            end
            StDbRelease: begin
                if (!pressed && cnt_q == DbLast) begin
                    level_d = 1'b0;
                    long_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign level     = level_q;
    assign press     = press_q;
    assign long_held = long_q;
    assign long_hit  = hit_q;

endmodule

// File: rtl/pcileech_sysctl.sv
// System control: tick counter, reset generation, buttons and LED muxing.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int unsigned NUM_BTN          = 2,
    parameter int unsigned NUM_LED          = 2,
    parameter int unsigned RST_BTN          = 1,
    parameter int unsigned POR_CYCLES       = 64,
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned LONGPRESS_CYCLES = 500000000,
    parameter int unsigned BLINK_BIT        = 24,
    parameter int unsigned BLINK_WINDOW_BIT = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_n,
    input  logic [NUM_LED-1:0]   led_src,
    input  logic [2*NUM_LED-1:0] led_mode,
    output logic [63:0]          tickcount,
    output logic                 sys_rst,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic [NUM_BTN-1:0]   btn_long,
    output logic                 cfg_reload,
    output logic [NUM_LED-1:0]   led_out
);

    logic [NUM_BTN-1:0] long_hit;
    logic [63:0]        tick_q;
    logic               sys_rst_q;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               blink;
    logic               pwron_window;
    logic               unused_long_hit;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        pcileech_sysctl_btn #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
        ) u_btn (
            .clk      (clk),
            .rst      (rst),
            .btn_n    (btn_n[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .long_held(btn_long[i]),
            .long_hit (long_hit[i])
        );
    end

    // Only the reset button's long-press pulse is used.
    assign cfg_reload      = long_hit[RST_BTN];
    assign unused_long_hit = ^long_hit;

    // Tick counter, held at zero while the reset button is pressed.
    always_ff @(posedge clk) begin
        if (rst || btn_level[RST_BTN]) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 64'd1;
        end
    end

    // sys_rst stays high until the tick counter has run past POR_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_rst_q <= 1'b1;
        end else begin
            sys_rst_q <= btn_level[RST_BTN] | (tick_q < 64'(POR_CYCLES));
        end
    end

    assign blink        = tick_q[BLINK_BIT];
    assign pwron_window = (tick_q[63:BLINK_WINDOW_BIT] == '0);

    // Per-LED mode select.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < int'(NUM_LED); i++) begin
            unique case (led_mode[2*i +: 2])
                LED_PASS:  led_d[i] = led_src[i];
                LED_INV:   led_d[i] = ~led_src[i];
                LED_BLINK: led_d[i] = blink;
                LED_PWRON: led_d[i] = led_src[i] ^ (blink & pwron_window);
                default:   led_d[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive, forced off during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign tickcount = tick_q;
    assign sys_rst   = sys_rst_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Directed bench for pcileech_sysctl with short debounce/long-press timings.
module tb_pcileech_sysctl;

    localparam int unsigned NUM_BTN = 2;
    localparam int unsigned NUM_LED = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_BTN-1:0]   btn_n;
    logic [NUM_LED-1:0]   led_src;
    logic [2*NUM_LED-1:0] led_mode;
    logic [63:0]          tickcount;
    logic                 sys_rst;
    logic [NUM_BTN-1:0]   btn_level;
    logic [NUM_BTN-1:0]   btn_press;
    logic [NUM_BTN-1:0]   btn_long;
    logic                 cfg_reload;
    logic [NUM_LED-1:0]   led_out;

    int n_tests = 0;
    int n_fail  = 0;

    pcileech_sysctl #(
        .NUM_BTN         (NUM_BTN),
        .NUM_LED         (NUM_LED),
        .RST_BTN         (1),
        .POR_CYCLES      (64),
        .DEBOUNCE_CYCLES (8),
        .LONGPRESS_CYCLES(32),
        .BLINK_BIT       (2),
        .BLINK_WINDOW_BIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .led_src   (led_src),
        .led_mode  (led_mode),
        .tickcount (tickcount),
        .sys_rst   (sys_rst),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_long  (btn_long),
        .cfg_reload(cfg_reload),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        btn_n    = '1;
        led_src  = 2'b00;
        led_mode = 4'b0101;  // inverted mode would drive 1s if not forced off
        repeat (3) step();
        n_tests++; if (tickcount !== 64'd0) begin n_fail++; $display("FAIL reset_tick: got %0d want 0", tickcount); end
        n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sysrst: got %b want 1", sys_rst); end
        n_tests++; if (btn_level !== 2'b00) begin n_fail++; $display("FAIL reset_level: got %b want 00", btn_level); end
        n_tests++; if (btn_press !== 2'b00) begin n_fail++; $display("FAIL reset_press: got %b want 00", btn_press); end
        n_tests++; if (btn_long !== 2'b00) begin n_fail++; $display("FAIL reset_long: got %b want 00", btn_long); end
        n_tests++; if (cfg_reload !== 1'b0) begin n_fail++; $display("FAIL reset_cfg: got %b want 0", cfg_reload); end
        n_tests++; if (led_out !== 2'b00) begin n_fail++; $display("FAIL reset_led: got %b want 00", led_out); end
    endtask

    task automatic test_por();
        led_mode = 4'b0000;
        rst      = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            step();
            n_tests++;
            if (tickcount !== 64'(k)) begin
                n_fail++; $display("FAIL por_tick[%0d]: got %0d want %0d", k, tickcount, k);
            end
            if (k == 1 || k == 64) begin
                n_tests++;
                if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL por_high[%0d]: got %b want 1", k, sys_rst); end
            end
            if (k == 65 || k == 66) begin
                n_tests++;
                if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL por_low[%0d]: got %b want 0", k, sys_rst); end
            end
        end
    endtask

    task automatic test_led();
        logic [63:0] t;
        logic [1:0]  exp;
        rst = 1'b1;
        step();
        led_mode = 4'b1111;
        led_src  = 2'b00;
        rst      = 1'b0;
        // Edge k registers LED from tick value k-1 (blink bit 2, window tick<16).
        for (int k = 1; k <= 24; k++) begin
            step();
            t   = 64'(k - 1);
            exp = {2{t[2] & (t < 64'd16)}};
            n_tests++;
            if (led_out !== exp) begin
                n_fail++; $display("FAIL led_pwron[%0d]: got %b want %b", k, led_out, exp);
            end
        end
        led_src  = 2'b11;
        led_mode = 4'b0101;
        step();
        n_tests++; if (led_out !== 2'b00) begin n_fail++; $display("FAIL led_inv: got %b want 00", led_out); end
        led_mode = 4'b0000;
        step();
        n_tests++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL led_pass: got %b want 11", led_out); end
        // LED0 blinks from tick bit 2, LED1 passes led_src; ticks 26..29 sampled.
        led_src  = 2'b10;
        led_mode = 4'b0010;
        for (int k = 26; k <= 29; k++) begin
            step();
            t   = 64'(k);
            exp = {1'b1, t[2]};
            n_tests++;
            if (led_out !== exp) begin
                n_fail++; $display("FAIL led_blink[%0d]: got %b want %b", k, led_out, exp);
            end
        end
        led_mode = 4'b0000;
        led_src  = 2'b00;
    endtask

    task automatic test_debounce();
        int seen;
        int edge_at;
        int pulses;
        seen = 0;
        btn_n[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (btn_level[0] || btn_press[0]) seen++;
        end
        btn_n[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (btn_level[0] || btn_press[0]) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL db_glitch: got %0d active cycles want 0", seen); end

        pulses  = 0;
        edge_at = 0;
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_press[0]) begin
                pulses++;
                edge_at = k;
            end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL db_pulses: got %0d want 1", pulses); end
        n_tests++; if (edge_at !== 11) begin n_fail++; $display("FAIL db_latency: got %0d want 11", edge_at); end
        n_tests++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL db_level: got %b want 1", btn_level[0]); end
        n_tests++; if (btn_long[0] !== 1'b0) begin n_fail++; $display("FAIL db_notlong: got %b want 0", btn_long[0]); end
        n_tests++; if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL db_sysrst: got %b want 0", sys_rst); end
        btn_n[0] = 1'b1;
        repeat (20) step();
        n_tests++; if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL db_release: got %b want 0", btn_level[0]); end
    endtask

    task automatic test_long_press();
        int   pulses;
        int   edge_at;
        logic long_at_fire;
        logic long_before;
        pulses       = 0;
        edge_at      = 0;
        long_at_fire = 1'b0;
        long_before  = 1'b1;
        btn_n[1] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (cfg_reload) begin
                pulses++;
                edge_at      = k;
                long_at_fire = btn_long[1];
            end
            if (k == 42) long_before = btn_long[1];
            if (k == 50) begin
                n_tests++;
                if (tickcount !== 64'd0) begin n_fail++; $display("FAIL lp_tick: got %0d want 0", tickcount); end
                n_tests++;
                if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL lp_sysrst: got %b want 1", sys_rst); end
            end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL lp_pulses: got %0d want 1", pulses); end
        n_tests++; if (edge_at !== 43) begin n_fail++; $display("FAIL lp_edge: got %0d want 43", edge_at); end
        n_tests++; if (long_at_fire !== 1'b1) begin n_fail++; $display("FAIL lp_long_fire: got %b want 1", long_at_fire); end
        n_tests++; if (long_before !== 1'b0) begin n_fail++; $display("FAIL lp_long_before: got %b want 0", long_before); end
    endtask

    task automatic test_release_bounce();
        int cfgs;
        int presses;
        int drops;
        cfgs    = 0;
        presses = 0;
        drops   = 0;
        btn_n[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (cfg_reload) cfgs++;
            if (btn_press[1]) presses++;
            if (!btn_level[1]) drops++;
        end
        btn_n[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cfg_reload) cfgs++;
            if (btn_press[1]) presses++;
            if (!btn_level[1]) drops++;
        end
        n_tests++; if (cfgs !== 0) begin n_fail++; $display("FAIL bounce_cfg: got %0d want 0", cfgs); end
        n_tests++; if (presses !== 0) begin n_fail++; $display("FAIL bounce_press: got %0d want 0", presses); end
        n_tests++; if (drops !== 0) begin n_fail++; $display("FAIL bounce_level: got %0d low cycles want 0", drops); end
        n_tests++; if (btn_long[1] !== 1'b1) begin n_fail++; $display("FAIL bounce_long: got %b want 1", btn_long[1]); end
    endtask

    task automatic test_release_por();
        int fall;
        fall = 0;
        btn_n[1] = 1'b1;
        for (int k = 1; k <= 20 && fall == 0; k++) begin
            step();
            if (btn_level[1] == 1'b0) fall = k;
        end
        n_tests++; if (fall !== 11) begin n_fail++; $display("FAIL rel_fall: got %0d want 11", fall); end
        n_tests++; if (btn_long[1] !== 1'b0) begin n_fail++; $display("FAIL rel_long: got %b want 0", btn_long[1]); end
        for (int j = 1; j <= 65; j++) begin
            step();
            if (j == 64) begin
                n_tests++;
                if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL rel_por_high: got %b want 1", sys_rst); end
            end
            if (j == 65) begin
                n_tests++;
                if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL rel_por_low: got %b want 0", sys_rst); end
                n_tests++;
                if (tickcount !== 64'd65) begin n_fail++; $display("FAIL rel_tick: got %0d want 65", tickcount); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int edge0;
        int edge1;
        led_src  = 2'b00;
        led_mode = 4'b0101;
        // Reset while button 0 is debouncing its press.
        btn_n[0] = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        n_tests++; if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_long !== 2'b00)
            begin n_fail++; $display("FAIL mid_db_btn: got %b/%b/%b want 00/00/00", btn_level, btn_press, btn_long); end
        n_tests++; if (sys_rst !== 1'b1 || tickcount !== 64'd0)
            begin n_fail++; $display("FAIL mid_db_rst: got %b/%0d want 1/0", sys_rst, tickcount); end
        n_tests++; if (led_out !== 2'b00 || cfg_reload !== 1'b0)
            begin n_fail++; $display("FAIL mid_db_led: got %b/%b want 00/0", led_out, cfg_reload); end
        // Release reset with both buttons held: FSMs must restart from idle.
        btn_n = 2'b00;
        rst   = 1'b0;
        edge0 = 0;
        edge1 = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (btn_press[0]) edge0 = k;
            if (btn_press[1]) edge1 = k;
        end
        n_tests++; if (edge0 !== 11) begin n_fail++; $display("FAIL mid_edge0: got %0d want 11", edge0); end
        n_tests++; if (edge1 !== 11) begin n_fail++; $display("FAIL mid_edge1: got %0d want 11", edge1); end
        n_tests++; if (btn_level !== 2'b11) begin n_fail++; $display("FAIL mid_held: got %b want 11", btn_level); end
        // Reset while both buttons are in the held state.
        rst = 1'b1;
        step();
        n_tests++; if (btn_level !== 2'b00 || btn_long !== 2'b00)
            begin n_fail++; $display("FAIL mid_held_btn: got %b/%b want 00/00", btn_level, btn_long); end
        n_tests++; if (sys_rst !== 1'b1 || tickcount !== 64'd0)
            begin n_fail++; $display("FAIL mid_held_rst: got %b/%0d want 1/0", sys_rst, tickcount); end
        n_tests++; if (led_out !== 2'b00) begin n_fail++; $display("FAIL mid_held_led: got %b want 00", led_out); end
        btn_n    = '1;
        led_mode = 4'b0000;
        rst      = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_por();
        test_led();
        test_debounce();
        test_long_press();
        test_release_bounce();
        test_release_por();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
